// File: rtl/multi_issue_skid_reg.sv
// -----------------------------------------------------------------------------
// multi_issue_skid_reg
//
// Inter-stage pipeline register for the multi-issue core. It carries a bundle
// of LANES instructions under a valid/ready handshake. A one-entry skid buffer
// holds a bundle that arrives while the output register is stalled, so the
// bundle is not dropped. On a redirect, lanes younger than the lowest
// redirecting lane are killed. A global flush empties both registers. The
// recover (redirect) sideband travels with its bundle.
//
// Configuration macro: MULTI_ISSUE_SKID_REG_ZERO_KILLED_EN
//   defined   : killed lanes, flushed entries and empty slots hold all-zero
//               payload. An empty or flushed output register presents zero
//               out_recover_pc. Instr 0 decodes as a NOP downstream.
//   undefined : only valid bits are cleared. Payload registers keep stale
//               data.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   flush              global kill of held and incoming bundles
//   in_valid/in_ready  upstream handshake (in_ready is registered)
//   in_lane_valid      per-lane valid, lane 0 is the oldest
//   in_payload         lane k at [k*DATA_W +: DATA_W]
//   in_kill_mask       bit k: lane k redirects, younger lanes are killed
//   in_recover_en/pc   redirect sideband
//   out_valid/ready    downstream handshake
//   out_lane_valid     per-lane valid
//   out_payload        per-lane payload
//   out_recover_en/pc  redirect sideband
// -----------------------------------------------------------------------------
module multi_issue_skid_reg #(
    parameter int LANES  = 2,
    parameter int DATA_W = 138,
    parameter int PC_W   = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES-1:0]        in_lane_valid,
    input  logic [LANES*DATA_W-1:0] in_payload,
    input  logic [LANES-1:0]        in_kill_mask,
    input  logic                    in_recover_en,
    input  logic [PC_W-1:0]         in_recover_pc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES-1:0]        out_lane_valid,
    output logic [LANES*DATA_W-1:0] out_payload,
    output logic                    out_recover_en,
    output logic [PC_W-1:0]         out_recover_pc
);

    localparam int PW = LANES * DATA_W;

    // Keep the lowest redirecting lane and every older lane. Only the bits
    // above the lowest set bit of the kill mask are cleared, so a zero mask
    // keeps every lane.
    function automatic logic [LANES-1:0] keep_mask(input logic [LANES-1:0] kill);
        logic [LANES-1:0] keep;
        logic             found;
        keep  = '0;
        found = 1'b0;
        for (int i = 0; i < LANES; i++) begin
            keep[i] = ~found;
            if (kill[i]) begin
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return keep;
    endfunction

    logic [LANES-1:0] skid_lane_valid_r;
    logic [PW-1:0]    skid_payload_r;
    logic             skid_recover_en_r;
    logic [PC_W-1:0]  skid_recover_pc_r;
    logic             skid_full_r;

    logic [LANES-1:0] eff_valid_s;
    logic [PW-1:0]    in_pay_s;
    logic             acc_s;
    logic             store_s;
    logic             adv_s;

    logic             nxt_out_valid_s;
    logic [LANES-1:0] nxt_out_lane_valid_s;
    logic [PW-1:0]    nxt_out_payload_s;
    logic             nxt_out_recover_en_s;
    logic [PC_W-1:0]  nxt_out_recover_pc_s;
    logic [LANES-1:0] nxt_skid_lane_valid_s;
    logic [PW-1:0]    nxt_skid_payload_s;
    logic             nxt_skid_recover_en_s;
    logic [PC_W-1:0]  nxt_skid_recover_pc_s;
    logic             nxt_skid_full_s;

    assign eff_valid_s = in_lane_valid & keep_mask(in_kill_mask);
    assign acc_s       = in_valid & in_ready & ~flush;
    // A bundle whose lanes were all invalid or killed completes its handshake
    // but is never stored, so it cannot create an empty output beat.
    assign store_s     = acc_s & (|eff_valid_s);
    assign adv_s       = ~out_valid | out_ready;

    // Incoming payload as it will be stored (killed lanes zeroed when enabled).
    always_comb begin
        in_pay_s = in_payload;
`ifdef MULTI_ISSUE_SKID_REG_ZERO_KILLED_EN
        for (int k = 0; k < LANES; k++) begin
            if (eff_valid_s[k]) begin
                in_pay_s[k*DATA_W +: DATA_W] = in_payload[k*DATA_W +: DATA_W];
            end else begin
                in_pay_s[k*DATA_W +: DATA_W] = '0;
            end
        end
`endif
    end

    // Next-state selection for the output and skid registers.
    always_comb begin
        nxt_out_valid_s       = out_valid;
        nxt_out_lane_valid_s  = out_lane_valid;
        nxt_out_payload_s     = out_payload;
        nxt_out_recover_en_s  = out_recover_en;
        nxt_out_recover_pc_s  = out_recover_pc;
        nxt_skid_lane_valid_s = skid_lane_valid_r;
        nxt_skid_payload_s    = skid_payload_r;
        nxt_skid_recover_en_s = skid_recover_en_r;
        nxt_skid_recover_pc_s = skid_recover_pc_r;
        nxt_skid_full_s       = skid_full_r;

        if (flush) begin
            nxt_out_valid_s       = 1'b0;
            nxt_out_lane_valid_s  = '0;
            nxt_out_recover_en_s  = 1'b0;
            nxt_skid_lane_valid_s = '0;
            nxt_skid_recover_en_s = 1'b0;
            nxt_skid_full_s       = 1'b0;
`ifdef MULTI_ISSUE_SKID_REG_ZERO_KILLED_EN
            nxt_out_payload_s     = '0;
            nxt_out_recover_pc_s  = '0;
            nxt_skid_payload_s    = '0;
            nxt_skid_recover_pc_s = '0;
`endif
        end else if (adv_s) begin
            if (skid_full_r) begin
                // in_ready was low, so no bundle can be accepted this cycle.
                nxt_out_valid_s      = 1'b1;
                nxt_out_lane_valid_s = skid_lane_valid_r;
                nxt_out_payload_s    = skid_payload_r;
                nxt_out_recover_en_s = skid_recover_en_r;
                nxt_out_recover_pc_s = skid_recover_pc_r;
                nxt_skid_full_s      = 1'b0;
            end else if (store_s) begin
                nxt_out_valid_s      = 1'b1;
                nxt_out_lane_valid_s = eff_valid_s;
                nxt_out_payload_s    = in_pay_s;
                nxt_out_recover_en_s = in_recover_en;
                nxt_out_recover_pc_s = in_recover_pc;
            end else begin
                nxt_out_valid_s      = 1'b0;
                nxt_out_lane_valid_s = '0;
                nxt_out_recover_en_s = 1'b0;
`ifdef MULTI_ISSUE_SKID_REG_ZERO_KILLED_EN
                nxt_out_payload_s    = '0;
                nxt_out_recover_pc_s = '0;
`endif
            end
        end else begin
            if (store_s) begin
                nxt_skid_lane_valid_s = eff_valid_s;
                nxt_skid_payload_s    = in_pay_s;
                nxt_skid_recover_en_s = in_recover_en;
                nxt_skid_recover_pc_s = in_recover_pc;
                nxt_skid_full_s       = 1'b1;
            end else begin
                nxt_skid_full_s       = skid_full_r;
            end
        end
    end

    // State registers; in_ready is the registered inverse of the next skid_full.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid         <= 1'b0;
            out_lane_valid    <= '0;
            out_payload       <= '0;
            out_recover_en    <= 1'b0;
            out_recover_pc    <= '0;
            skid_lane_valid_r <= '0;
            skid_payload_r    <= '0;
            skid_recover_en_r <= 1'b0;
            skid_recover_pc_r <= '0;
            skid_full_r       <= 1'b0;
            in_ready          <= 1'b1;
        end else begin
            out_valid         <= nxt_out_valid_s;
            out_lane_valid    <= nxt_out_lane_valid_s;
            out_payload       <= nxt_out_payload_s;
            out_recover_en    <= nxt_out_recover_en_s;
            out_recover_pc    <= nxt_out_recover_pc_s;
            skid_lane_valid_r <= nxt_skid_lane_valid_s;
            skid_payload_r    <= nxt_skid_payload_s;
            skid_recover_en_r <= nxt_skid_recover_en_s;
            skid_recover_pc_r <= nxt_skid_recover_pc_s;
            skid_full_r       <= nxt_skid_full_s;
            in_ready          <= ~nxt_skid_full_s;
        end
    end

endmodule

// File: doc/multi_issue_skid_reg.md
# multi_issue_skid_reg

Parametrised inter-stage pipeline register for the multi-issue core, replacing the fixed two-lane stage registers between execute sub-stages. It carries a bundle of `LANES` instructions per cycle under a valid/ready handshake, with a one-entry skid buffer so stalls hold the bundle instead of dropping it. It applies in-bundle younger-lane kill on a redirect, a global flush, and carries the recover (redirect) sideband alongside the bundle.

## Interface
- `LANES`, default 2: issue width; lane 0 is the oldest instruction in the bundle.
- `DATA_W`, default 138: per-lane payload width (instr, rd, pc, alu_result, read_data2), treated as opaque.
- `PC_W`, default 32: recover PC width.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `flush` in 1: global kill of all held and incoming bundles.
- `in_valid` in 1: upstream bundle present.
- `in_ready` out 1: block can accept a bundle; registered.
- `in_lane_valid` in `LANES`: per-lane valid.
- `in_payload` in `LANES*DATA_W`: lane k occupies bits [k*DATA_W +: DATA_W].
- `in_kill_mask` in `LANES`: bit k set means lane k redirects; lanes younger than k are killed.
- `in_recover_en` in 1: redirect sideband.
- `in_recover_pc` in `PC_W`: redirect sideband.
- `out_valid` out 1: bundle presented downstream.
- `out_ready` in 1: downstream accepts.
- `out_lane_valid` out `LANES`: per-lane valid.
- `out_payload` out `LANES*DATA_W`: per-lane payload.
- `out_recover_en` out 1: redirect sideband.
- `out_recover_pc` out `PC_W`: redirect sideband.

## Operation
- State:
  - Output register: `out_*` plus `out_valid`.
  - Skid register: same fields plus `skid_full`.
- Accept: `acc = in_valid & in_ready & ~flush`.
- Kill:
  - k is the lowest set bit of `in_kill_mask`.
  - Stored lane valid = `in_lane_valid & ~younger(k)`, where `younger(k)` sets every bit above k.
  - Lane k itself is kept.
  - A mask of 0 kills nothing.
- Empty bundle: an accepted bundle whose effective lane valid is all-zero is consumed (handshake completes) but not stored. `out_valid` is not set for it.
- Sideband: `recover_en`/`recover_pc` travel with their bundle and are stored even if only lane 0 survives.
- Advance: `adv = ~out_valid | out_ready`. When `adv`:
  - If `skid_full`, skid moves to the output register and `skid_full` clears.
  - Otherwise an accepted bundle, if any, goes to the output register.
  - Otherwise `out_valid` clears.
- Stall capture: when `~adv` and `acc`, the bundle goes to skid and `skid_full` sets.
- Ready: `in_ready` next = ~(next `skid_full`).
- Flush, highest priority:
  - Next cycle, `out_valid`, `out_lane_valid`, `out_recover_en` and `skid_full` are 0.
  - The incoming bundle is discarded.
  - `in_ready` returns to 1.
- Ordering: bundles leave in acceptance order; no bundle is duplicated or lost except by kill or flush.

## Timing
- Reset (async, while `rst`=1):
  - All outputs 0 except `in_ready`=1.
  - `skid_full`=0.
- Latency: one cycle from accept to `out_valid` when the output register is empty or draining.
- Throughput: one bundle per cycle with `out_ready` held high; the skid stays empty.
- Stall with the output register full and a bundle accepted: the bundle goes to skid, and `in_ready`=0 from the next cycle.
- Skid full and `out_ready` asserted:
  - Skid drains to output on that edge.
  - `in_ready`=1 next cycle.
  - No bundle is accepted in the draining cycle, since `in_ready` was 0.
- Simultaneous `flush` and `out_ready`: flush wins; no bundle reaches the output.
- Reset asserted mid-stall: contents are discarded immediately and asynchronously.
- `out_payload`/`out_recover_pc` are unconstrained when `out_valid`=0, except as set by the configuration macro below.

## Configuration
- Macro: `MULTI_ISSUE_SKID_REG_ZERO_KILLED_EN`.
- Defined:
  - Killed lanes, flushed entries and empty slots store all-zero payload.
  - An empty or flushed output register presents zero `out_recover_pc`.
  - Instr = 0 acts as a NOP for downstream decode.
- Undefined:
  - Only valid bits are cleared; payload registers retain stale data.
  - Payload flops need no reset or clear mux.

## Test plan
- Reset, then LANES=2 bundle {lane_valid=2'b11, kill=0}, out_ready=1 -> next cycle out_valid=1, out_lane_valid=2'b11, payloads match; in_ready stays 1.
- Bundle with kill=2'b01, LANES=4, lane_valid=4'b1111 -> out_lane_valid=4'b0001, recover_en/pc passed through; with the macro defined, lanes 1–3 payload = 0.
- out_ready=0 while output full, send bundle B -> in_ready=0 next cycle; raise out_ready -> A then B emerge on consecutive cycles, no loss or duplication.
- Skid full, assert flush together with out_ready=1 -> next cycle out_valid=0, skid_full=0, in_ready=1; the following bundle C emerges alone.
- Bundle with lane_valid=0 accepted -> out_valid stays 0; the surrounding bundles D and E appear back-to-back.
- Assert rst asynchronously mid-stall with skid full -> outputs clear before the next clk edge; in_ready=1 after deassertion.
